// File: rtl/vip_decoder_pkg.sv
// Shared types and constants for the Avalon-ST video packet decoder.
// Optional build macro: VIP_DECODER_ZERO_DIM_REJECT_EN (see parser).
package vip_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VIDEO,
    ST_CONTROL,
    ST_DISCARD
  } state_t;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
  localparam int         CTRL_NIBBLES   = 9;

  function automatic state_t hdr_state(
    input logic [3:0] pkt_type
  );
    state_t s;
    s = ST_DISCARD;
    if (pkt_type == PKT_TYPE_VIDEO)
      s = ST_VIDEO;
    else if (pkt_type == PKT_TYPE_CTRL)
      s = ST_CONTROL;
    return s;
  endfunction

endpackage

// File: rtl/vip_avalon_st_video_decoder_if.sv
// Stream bundle between source, decoder and flow-control input stage.
// slave = decoder view, master = source/sink environment view.
interface vip_avalon_st_video_decoder_if #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
);
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  logic          din_ready;
  logic          din_valid;
  logic [DW-1:0] din_data;
  logic          din_startofpacket;
  logic          din_endofpacket;

  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;

  logic [15:0]   decoder_width;
  logic [15:0]   decoder_height;
  logic [3:0]    decoder_interlaced;
  logic          decoder_end_of_video;
  logic          decoder_is_video;
  logic          decoder_vip_ctrl_valid;

  modport slave (
    output din_ready,
    input  din_valid,
    input  din_data,
    input  din_startofpacket,
    input  din_endofpacket,
    input  dout_ready,
    output dout_valid,
    output dout_data,
    output decoder_width,
    output decoder_height,
    output decoder_interlaced,
    output decoder_end_of_video,
    output decoder_is_video,
    output decoder_vip_ctrl_valid
  );

  modport master (
    input  din_ready,
    output din_valid,
    output din_data,
    output din_startofpacket,
    output din_endofpacket,
    output dout_ready,
    input  dout_valid,
    input  dout_data,
    input  decoder_width,
    input  decoder_height,
    input  decoder_interlaced,
    input  decoder_end_of_video,
    input  decoder_is_video,
    input  decoder_vip_ctrl_valid
  );

endinterface

// File: rtl/vip_ctrl_packet_parser.sv
// Control packet nibble parser with shadow fields and commit strobe.
// VIP_DECODER_ZERO_DIM_REJECT_EN: drop packets with zero width/height.
module vip_ctrl_packet_parser
  import vip_decoder_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          beat,
  input  logic [4*SYMBOLS_PER_BEAT-1:0] nibs,
  input  logic                          eop,
  output logic                          commit,
  output logic [15:0]                   width,
  output logic [15:0]                   height,
  output logic [3:0]                    interlaced
);

  logic [3:0]  cnt;
  logic [15:0] sh_w;
  logic [15:0] sh_h;
  logic [3:0]  sh_i;
  logic [15:0] nx_w;
  logic [15:0] nx_h;
  logic [3:0]  nx_i;
  logic [4:0]  sum;
  logic        full;
  logic        dim_ok;

  // Merge this beat's nibbles into the shadow copy at the running index.
  always_comb begin : merge
    int k;
    k    = 0;
    nx_w = sh_w;
    nx_h = sh_h;
    nx_i = sh_i;
    for (int j = 0; j < SYMBOLS_PER_BEAT; j++) begin
      k = int'(cnt) + j;
      if (k < 4)
        nx_w[(3-k)*4 +: 4] = nibs[j*4 +: 4];
      else if (k < 8)
        nx_h[(7-k)*4 +: 4] = nibs[j*4 +: 4];
      else if (k == CTRL_NIBBLES - 1)
        nx_i = nibs[j*4 +: 4];
    end
  end

  assign sum  = {1'b0, cnt} + 5'(SYMBOLS_PER_BEAT);
  assign full = sum >= 5'(CTRL_NIBBLES);

`ifdef VIP_DECODER_ZERO_DIM_REJECT_EN
  assign dim_ok = (nx_w != 16'h0) && (nx_h != 16'h0);
`else
  assign dim_ok = 1'b1;
`endif

  assign commit     = beat & eop & full & dim_ok;
  assign width      = nx_w;
  assign height     = nx_h;
  assign interlaced = nx_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 4'd0;
      sh_w <= 16'h0;
      sh_h <= 16'h0;
      sh_i <= 4'h0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (beat) begin
      sh_w <= nx_w;
      sh_h <= nx_h;
      sh_i <= nx_i;
      if (eop)
        cnt <= 4'd0;
      else if (full)
        cnt <= 4'(CTRL_NIBBLES);
      else
        cnt <= sum[3:0];
    end
  end

endmodule

// File: rtl/vip_avalon_st_video_decoder.sv
// Avalon-ST VIP packet decoder: header classify, control parse, video forward.
// VIP_DECODER_ZERO_DIM_REJECT_EN is honoured inside the control parser.
module vip_avalon_st_video_decoder
  import vip_decoder_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input logic                       clk,
  input logic                       rst,
  vip_avalon_st_video_decoder_if.slave bus
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int NW = 4 * SYMBOLS_PER_BEAT;

  state_t          state;
  state_t          state_nx;
  logic            acc;
  logic            sop;
  logic            eop;
  logic            ld_out;
  logic            ctrl_beat;
  logic            ctrl_clr;
  logic            commit;
  logic [NW-1:0]   nibs;
  logic [15:0]     p_w;
  logic [15:0]     p_h;
  logic [3:0]      p_i;

  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic            o_eov;
  logic            o_vid;
  logic [15:0]     r_w;
  logic [15:0]     r_h;
  logic [3:0]      r_i;
  logic            r_cv;

  assign bus.din_ready = ~o_valid | bus.dout_ready;
  assign acc = bus.din_valid & bus.din_ready;
  assign sop = bus.din_startofpacket;
  assign eop = bus.din_endofpacket;

  always_comb begin
    nibs = '0;
    for (int j = 0; j < SYMBOLS_PER_BEAT; j++)
      nibs[j*4 +: 4] = bus.din_data[j*BITS_PER_SYMBOL +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Any accepted SOP is a header, regardless of the current state.
  always_comb begin
    state_nx  = state;
    ld_out    = 1'b0;
    ctrl_beat = 1'b0;
    ctrl_clr  = 1'b0;
    if (acc) begin
      if (sop) begin
        ctrl_clr = 1'b1;
        state_nx = eop ? ST_IDLE
                       : hdr_state(bus.din_data[3:0]);
      end else begin
        unique case (state)
          ST_IDLE: state_nx = ST_IDLE;
          ST_VIDEO: begin
            ld_out = 1'b1;
            if (eop) state_nx = ST_IDLE;
          end
          ST_CONTROL: begin
            ctrl_beat = 1'b1;
            if (eop) state_nx = ST_IDLE;
          end
          ST_DISCARD: begin
            if (eop) state_nx = ST_IDLE;
          end
          default: state_nx = ST_IDLE;
        endcase
      end
    end
  end

  vip_ctrl_packet_parser #(
    .SYMBOLS_PER_BEAT (SYMBOLS_PER_BEAT)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .clear      (ctrl_clr),
    .beat       (ctrl_beat),
    .nibs       (nibs),
    .eop        (eop),
    .commit     (commit),
    .width      (p_w),
    .height     (p_h),
    .interlaced (p_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_eov   <= 1'b0;
      o_vid   <= 1'b0;
      r_w     <= 16'h0;
      r_h     <= 16'h0;
      r_i     <= 4'h0;
      r_cv    <= 1'b0;
    end else begin
      if (ld_out) begin
        o_valid <= 1'b1;
        o_data  <= bus.din_data;
        o_eov   <= eop;
        o_vid   <= 1'b1;
      end else if (bus.dout_ready) begin
        o_valid <= 1'b0;
      end
      if (commit) begin
        r_w  <= p_w;
        r_h  <= p_h;
        r_i  <= p_i;
        r_cv <= 1'b1;
      end
    end
  end

  assign bus.dout_valid             = o_valid;
  assign bus.dout_data              = o_data;
  assign bus.decoder_end_of_video   = o_eov;
  assign bus.decoder_is_video       = o_vid;
  assign bus.decoder_width          = r_w;
  assign bus.decoder_height         = r_h;
  assign bus.decoder_interlaced     = r_i;
  assign bus.decoder_vip_ctrl_valid = r_cv;

endmodule

// File: tb/tb_vip_avalon_st_video_decoder.sv
// Scoreboard bench for vip_avalon_st_video_decoder (SPB=3, BPS=8).
// Honours VIP_DECODER_ZERO_DIM_REJECT_EN for zero-dimension expectations.
module tb_vip_avalon_st_video_decoder;

  typedef struct packed {
    logic [23:0] d;
    logic        eov;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  logic [15:0] w_exp;
  logic [15:0] h_exp;
  logic [3:0]  i_exp;
  logic        cv_exp;

  logic        held;
  logic [23:0] held_d;

  vip_avalon_st_video_decoder_if #(
    .BITS_PER_SYMBOL  (8),
    .SYMBOLS_PER_BEAT (3)
  ) bus ();

  vip_avalon_st_video_decoder #(
    .BITS_PER_SYMBOL  (8),
    .SYMBOLS_PER_BEAT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: scoreboard pop, stall hold and din_ready relation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if (bus.din_ready !== (!bus.dout_valid || bus.dout_ready)) begin
        errors++;
        $display("FAIL din_ready: got %b need %b", bus.din_ready,
                 (!bus.dout_valid || bus.dout_ready));
      end
      if (held) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout_data !== held_d) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h need v=1 d=%h",
                   bus.dout_valid, bus.dout_data, held_d);
        end
      end
      if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h need none",
                   bus.dout_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout_data !== e.d ||
              bus.decoder_end_of_video !== e.eov ||
              bus.decoder_is_video !== 1'b1) begin
            errors++;
            $display("FAIL beat: got d=%h eov=%b vid=%b need d=%h eov=%b vid=1",
                     bus.dout_data, bus.decoder_end_of_video,
                     bus.decoder_is_video, e.d, e.eov);
          end
        end
      end
      held   = (bus.dout_valid === 1'b1) && (bus.dout_ready === 1'b0);
      held_d = bus.dout_data;
    end else begin
      held = 1'b0;
    end
  end

  function automatic logic [23:0] vid(input int i);
    return {8'(3*i+3), 8'(3*i+2), 8'(3*i+1)};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [23:0] d, input logic sop,
                           input logic eop, output int waits);
    logic rdy;
    waits = 0;
    bus.din_valid         = 1'b1;
    bus.din_data          = d;
    bus.din_startofpacket = sop;
    bus.din_endofpacket   = eop;
    forever begin
      @(negedge clk);
      rdy = bus.din_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) break;
      waits++;
      if (waits > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept need accept in 100");
        break;
      end
    end
    bus.din_valid         = 1'b0;
    bus.din_startofpacket = 1'b0;
    bus.din_endofpacket   = 1'b0;
  endtask

  task automatic send_video(input int n, input logic [23:0] xr,
                            output int wt);
    int          w;
    logic [23:0] d;
    wt = 0;
    send_beat(24'h123450, 1'b1, 1'b0, w);
    wt += w;
    for (int i = 0; i < n; i++) begin
      d = vid(i) ^ xr;
      send_beat(d, 1'b0, (i == n-1), w);
      wt += w;
      exp_q.push_back(exp_t'{d: d, eov: (i == n-1)});
    end
  endtask

  // Nibble n of {w,h,il} goes to symbol n%3 of beat n/3, noise above.
  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h,
                           input logic [3:0] il);
    logic [35:0] v;
    logic [23:0] d;
    int          wt;
    v = {w, h, il};
    send_beat(24'h00000F, 1'b1, 1'b0, wt);
    for (int b = 0; b < 3; b++) begin
      d = 24'h505050;
      for (int j = 0; j < 3; j++)
        d[j*8 +: 4] = v[35 - 4*(3*b+j) -: 4];
      send_beat(d, 1'b0, (b == 2), wt);
    end
  endtask

  task automatic chk_regs(input string nm);
    checks++;
    if (bus.decoder_width !== w_exp || bus.decoder_height !== h_exp ||
        bus.decoder_interlaced !== i_exp ||
        bus.decoder_vip_ctrl_valid !== cv_exp) begin
      errors++;
      $display("FAIL %s: got w=%h h=%h i=%h cv=%b need w=%h h=%h i=%h cv=%b",
               nm, bus.decoder_width, bus.decoder_height,
               bus.decoder_interlaced, bus.decoder_vip_ctrl_valid,
               w_exp, h_exp, i_exp, cv_exp);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.dout_valid === 1'b1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending v=%b need 0 pending v=0",
               nm, exp_q.size(), bus.dout_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_data = '0;
    bus.din_startofpacket = 1'b0;
    bus.din_endofpacket = 1'b0;
    bus.dout_ready = 1'b0;
    w_exp = 16'h0; h_exp = 16'h0; i_exp = 4'h0; cv_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout_data !== 24'h0 ||
        bus.decoder_end_of_video !== 1'b0 ||
        bus.decoder_is_video !== 1'b0 || bus.din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h eov=%b vid=%b rdy=%b need 0 0 0 0 1",
               bus.dout_valid, bus.dout_data, bus.decoder_end_of_video,
               bus.decoder_is_video, bus.din_ready);
    end
    chk_regs("reset_regs");
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.din_ready !== 1'b1 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b v=%b need rdy=1 v=0",
               bus.din_ready, bus.dout_valid);
    end
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_control();
    int wt;
    send_beat(24'h00000F, 1'b1, 1'b0, wt);
    send_beat(24'h585750, 1'b0, 1'b0, wt);
    send_beat(24'h040000, 1'b0, 1'b0, wt);
    chk_regs("ctrl_before_eop");
    send_beat(24'h030803, 1'b0, 1'b1, wt);
    w_exp = 16'h0780; h_exp = 16'h0438; i_exp = 4'h3; cv_exp = 1'b1;
    chk_regs("ctrl_update");
    wait_drain("ctrl");
  endtask

  task automatic test_video();
    int wt;
    send_beat(24'h000000, 1'b1, 1'b0, wt);
    send_beat(vid(0), 1'b0, 1'b0, wt);
    exp_q.push_back(exp_t'{d: vid(0), eov: 1'b0});
    #1;
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout_data !== 24'h030201) begin
      errors++;
      $display("FAIL video_latency: got v=%b d=%h need v=1 d=030201",
               bus.dout_valid, bus.dout_data);
    end
    for (int i = 1; i < 4; i++) begin
      send_beat(vid(i), 1'b0, (i == 3), wt);
      exp_q.push_back(exp_t'{d: vid(i), eov: (i == 3)});
    end
    wait_drain("video");
  endtask

  task automatic test_stall();
    int wt;
    fork
      send_video(4, 24'h000000, wt);
      for (int c = 0; c < 40; c++) begin
        bus.dout_ready = (c % 2 == 0);
        @(posedge clk);
        #1;
      end
    join
    bus.dout_ready = 1'b1;
    checks++;
    if (wt == 0) begin
      errors++;
      $display("FAIL stall_backpressure: got %0d wait cycles need >0", wt);
    end
    wait_drain("stall");
  endtask

  task automatic test_trunc_discard();
    int wt;
    int tw;
    tw = 0;
    send_beat(24'h00000F, 1'b1, 1'b0, wt); tw += wt;
    send_beat(24'h010101, 1'b0, 1'b0, wt); tw += wt;
    send_beat(24'h020202, 1'b0, 1'b1, wt); tw += wt;
    #1;
    chk_regs("trunc_regs");
    send_beat(24'h000003, 1'b1, 1'b0, wt); tw += wt;
    send_beat(24'hAABBCC, 1'b0, 1'b0, wt); tw += wt;
    send_beat(24'h000000, 1'b0, 1'b0, wt); tw += wt;
    send_beat(24'h112233, 1'b0, 1'b1, wt); tw += wt;
    checks++;
    if (tw != 0) begin
      errors++;
      $display("FAIL trunc_ready: got %0d stalls need 0", tw);
    end
    chk_regs("discard_regs");
    wait_drain("discard");
  endtask

  task automatic test_abort();
    int wt;
    send_beat(24'h000000, 1'b1, 1'b0, wt);
    for (int i = 0; i < 2; i++) begin
      send_beat(vid(i) ^ 24'h808080, 1'b0, 1'b0, wt);
      exp_q.push_back(exp_t'{d: vid(i) ^ 24'h808080, eov: 1'b0});
    end
    send_ctrl(16'h0500, 16'h02D0, 4'h0);
    w_exp = 16'h0500; h_exp = 16'h02D0; i_exp = 4'h0; cv_exp = 1'b1;
    chk_regs("abort_ctrl");
    wait_drain("abort");
  endtask

  task automatic test_sop_eop();
    int wt;
    send_beat(24'h000000, 1'b1, 1'b1, wt);
    send_beat(24'h445566, 1'b0, 1'b1, wt);
    send_beat(24'h00000F, 1'b1, 1'b1, wt);
    send_beat(24'h0F0F0F, 1'b0, 1'b0, wt);
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pkt: got v=%b need v=0", bus.dout_valid);
    end
    chk_regs("empty_ctrl");
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_dim();
    send_ctrl(16'h0000, 16'h0100, 4'h1);
`ifndef VIP_DECODER_ZERO_DIM_REJECT_EN
    w_exp = 16'h0000; h_exp = 16'h0100; i_exp = 4'h1; cv_exp = 1'b1;
`endif
    chk_regs("zero_dim");
  endtask

  task automatic test_back_to_back();
    int wt;
    int tw;
    tw = 0;
    send_video(3, 24'h111111, wt); tw += wt;
    send_video(2, 24'h222222, wt); tw += wt;
    checks++;
    if (tw != 0) begin
      errors++;
      $display("FAIL b2b_ready: got %0d stalls need 0", tw);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid();
    int wt;
    send_beat(24'h000000, 1'b1, 1'b0, wt);
    send_beat(24'h999999, 1'b0, 1'b0, wt);
    exp_q.push_back(exp_t'{d: 24'h999999, eov: 1'b0});
    send_beat(24'h00000F, 1'b1, 1'b0, wt);
    send_beat(24'h777777, 1'b0, 1'b0, wt);
    rst = 1'b0;
    #1;
    w_exp = 16'h0; h_exp = 16'h0; i_exp = 4'h0; cv_exp = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: got v=%b need v=0", bus.dout_valid);
    end
    chk_regs("mid_reset_regs");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_beat(24'h777777, 1'b0, 1'b0, wt);
    send_beat(24'h777777, 1'b0, 1'b1, wt);
    chk_regs("post_reset_drop");
    send_video(1, 24'h0000AA, wt);
    wait_drain("reset_mid");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    held   = 1'b0;
    held_d = '0;
    test_reset();
    test_control();
    test_video();
    test_stall();
    test_trunc_discard();
    test_abort();
    test_sop_eop();
    test_zero_dim();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
